// File: rtl/preg_freelist_pkg.sv
// Shared rename-pool sizing and types used by the free list, RAT, ROB and RS.
package preg_freelist_pkg;

  localparam int FL_NUM_PREGS = 128;
  localparam int FL_NUM_AREGS = 32;
  localparam int PREG_W       = $clog2(FL_NUM_PREGS);
  localparam int COUNT_W      = PREG_W + 1;

  typedef logic [PREG_W-1:0]  preg_t;
  typedef logic [COUNT_W-1:0] count_t;

endpackage

// File: rtl/preg_freelist.sv
// Dual-port physical register free list: circular FIFO of free pregs, all-or-nothing
// dual allocation, dual release. Optional duplicate-free checker: FREELIST_DBL_FREE_CHK_EN.
module preg_freelist
  import preg_freelist_pkg::*;
#(
  parameter int NUM_PREGS = FL_NUM_PREGS,
  parameter int NUM_AREGS = FL_NUM_AREGS,
  localparam int PW = $clog2(NUM_PREGS),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alloc_req_1,
  input  logic          alloc_req_2,
  output logic          alloc_gnt_1,
  output logic          alloc_gnt_2,
  output logic [PW-1:0] alloc_preg_1,
  output logic [PW-1:0] alloc_preg_2,
  input  logic          free_en_1,
  input  logic          free_en_2,
  input  logic [PW-1:0] free_preg_1,
  input  logic [PW-1:0] free_preg_2,
`ifdef FREELIST_DBL_FREE_CHK_EN
  output logic          err_dbl_free,
`endif
  output logic [CW-1:0] free_count,
  output logic          empty
);

  localparam logic [CW-1:0] CAPACITY   = CW'(NUM_PREGS - 1);
  localparam logic [CW-1:0] RESET_CNT  = CW'(NUM_PREGS - NUM_AREGS);

  logic [PW-1:0] entries [NUM_PREGS];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;

  logic [PW-1:0] head_p1, tail_p1;
  logic [1:0]    demand, n_gnt, n_free;
  logic          can_grant;
  logic          v1, v2, acc1, acc2;
  logic [CW-1:0] avail;

  assign head_p1 = head + PW'(1);
  assign tail_p1 = tail + PW'(1);

  // Handshake: a request is taken on the edge only when its grant is high in that cycle;
  // the group is granted whole or stalled whole, from the registered count only.
  assign demand       = {1'b0, alloc_req_1} + {1'b0, alloc_req_2};
  assign can_grant    = !reset && (count >= CW'(demand));
  assign alloc_gnt_1  = alloc_req_1 && can_grant;
  assign alloc_gnt_2  = alloc_req_2 && can_grant;
  assign alloc_preg_1 = entries[head];
  assign alloc_preg_2 = alloc_req_1 ? entries[head_p1] : entries[head];
  assign n_gnt        = {1'b0, alloc_gnt_1} + {1'b0, alloc_gnt_2};
  assign free_count   = count;
  assign empty        = (count == '0);

`ifdef FREELIST_DBL_FREE_CHK_EN
  logic [NUM_PREGS-1:0] in_list;
  logic                 dup1, dup2;
`endif

  always_comb begin
    v1 = free_en_1 && (free_preg_1 != '0);
    v2 = free_en_2 && (free_preg_2 != '0);
`ifdef FREELIST_DBL_FREE_CHK_EN
    dup1 = v1 && in_list[free_preg_1];
    dup2 = v2 && (in_list[free_preg_2] || (v1 && (free_preg_1 == free_preg_2)));
    v1   = v1 && !dup1;
    v2   = v2 && !dup2;
`endif
    // Overflow guard: a release beyond capacity is dropped rather than wrapping the FIFO.
    avail  = count - CW'(n_gnt);
    acc1   = v1 && (avail < CAPACITY);
    acc2   = v2 && ((avail + CW'(acc1)) < CAPACITY);
    n_free = {1'b0, acc1} + {1'b0, acc2};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PREGS; i++)
        entries[i] <= (i < NUM_PREGS - NUM_AREGS) ? PW'(i + NUM_AREGS) : '0;
      head  <= '0;
      tail  <= PW'(NUM_PREGS - NUM_AREGS);
      count <= RESET_CNT;
    end else begin
      if (acc1) entries[tail] <= free_preg_1;
      if (acc2) entries[acc1 ? tail_p1 : tail] <= free_preg_2;
      head  <= head + PW'(n_gnt);
      tail  <= tail + PW'(n_free);
      count <= count - CW'(n_gnt) + CW'(n_free);
    end
  end

`ifdef FREELIST_DBL_FREE_CHK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PREGS; i++) in_list[i] <= (i >= NUM_AREGS);
      err_dbl_free <= 1'b0;
    end else begin
      if (alloc_gnt_1) in_list[alloc_preg_1] <= 1'b0;
      if (alloc_gnt_2) in_list[alloc_preg_2] <= 1'b0;
      if (acc1) in_list[free_preg_1] <= 1'b1;
      if (acc2) in_list[free_preg_2] <= 1'b1;
      if (dup1 || dup2) err_dbl_free <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_preg_freelist.sv
// Directed and randomized checks of preg_freelist against a queue-based free-list model.
module tb_preg_freelist;

  logic       clk;
  logic       reset;
  logic       alloc_req_1, alloc_req_2;
  logic       alloc_gnt_1, alloc_gnt_2;
  logic [6:0] alloc_preg_1, alloc_preg_2;
  logic       free_en_1, free_en_2;
  logic [6:0] free_preg_1, free_preg_2;
  logic [7:0] free_count;
  logic       empty;
`ifdef FREELIST_DBL_FREE_CHK_EN
  logic       err_dbl_free;
`endif

  int checks   = 0;
  int failures = 0;

  logic [6:0] fl[$];     // model: free pregs in allocation order
  logic [6:0] out_q[$];  // model: pregs currently handed out

  preg_freelist dut (
    .clk          (clk),
    .reset        (reset),
    .alloc_req_1  (alloc_req_1),
    .alloc_req_2  (alloc_req_2),
    .alloc_gnt_1  (alloc_gnt_1),
    .alloc_gnt_2  (alloc_gnt_2),
    .alloc_preg_1 (alloc_preg_1),
    .alloc_preg_2 (alloc_preg_2),
    .free_en_1    (free_en_1),
    .free_en_2    (free_en_2),
    .free_preg_1  (free_preg_1),
    .free_preg_2  (free_preg_2),
`ifdef FREELIST_DBL_FREE_CHK_EN
    .err_dbl_free (err_dbl_free),
`endif
    .free_count   (free_count),
    .empty        (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fl.delete();
    out_q.delete();
    for (int p = 32; p < 128; p++) fl.push_back(7'(p));
  endtask

  task automatic out_remove(input logic [6:0] p);
    for (int i = 0; i < out_q.size(); i++)
      if (out_q[i] == p) begin
        out_q.delete(i);
        return;
      end
  endtask

  task automatic drive_idle();
    alloc_req_1 = 0; alloc_req_2 = 0;
    free_en_1 = 0; free_en_2 = 0;
    free_preg_1 = '0; free_preg_2 = '0;
  endtask

  // One cycle, starting and ending at a negedge; checks against the model.
  task automatic cycle(input bit r1, input bit r2, input bit f1e, input logic [6:0] f1,
                       input bit f2e, input logic [6:0] f2,
                       output bit g1, output bit g2, output logic [6:0] p1, output logic [6:0] p2);
    bit eg;
    alloc_req_1 = r1; alloc_req_2 = r2;
    free_en_1 = f1e; free_preg_1 = f1;
    free_en_2 = f2e; free_preg_2 = f2;
    #1;
    eg = fl.size() >= (int'(r1) + int'(r2));
    chk("gnt_1", alloc_gnt_1, r1 && eg);
    chk("gnt_2", alloc_gnt_2, r2 && eg);
    if (eg && r1) chk("preg_1", alloc_preg_1, fl[0]);
    if (eg && r2) chk("preg_2", alloc_preg_2, r1 ? fl[1] : fl[0]);
    g1 = alloc_gnt_1; g2 = alloc_gnt_2; p1 = alloc_preg_1; p2 = alloc_preg_2;
    @(posedge clk); #1;
    if (eg) begin
      if (r1) out_q.push_back(fl.pop_front());
      if (r2) out_q.push_back(fl.pop_front());
    end
    if (f1e && f1 != 0) fl.push_back(f1);
    if (f2e && f2 != 0) fl.push_back(f2);
    chk("free_count", free_count, fl.size());
    chk("empty", empty, fl.size() == 0);
    drive_idle();
    @(negedge clk);
  endtask

  initial begin
    bit g1, g2;
    logic [6:0] p1, p2, fa, fb;
    bit fae, fbe;

    drive_idle();
    reset = 1;
    model_reset();
    @(negedge clk);
    alloc_req_1 = 1; alloc_req_2 = 1;
    #1;
    chk("rst_gnt_1", alloc_gnt_1, 0);
    chk("rst_gnt_2", alloc_gnt_2, 0);
    @(negedge clk);
    drive_idle();
    reset = 0;
    #1;
    chk("rst_count", free_count, 96);
    chk("rst_empty", empty, 0);
    chk("rst_preg_1", alloc_preg_1, 32);
    chk("rst_preg_2_noreq", alloc_preg_2, 32);
`ifdef FREELIST_DBL_FREE_CHK_EN
    chk("rst_err", err_dbl_free, 0);
`endif
    alloc_req_1 = 1; #1;
    chk("rst_preg_2_req1", alloc_preg_2, 33);
    alloc_req_1 = 0;
    @(negedge clk);

    // dual allocation right after reset
    cycle(1, 1, 0, 0, 0, 0, g1, g2, p1, p2);
    chk("pair_gnt", {g1, g2}, 2'b11);
    chk("pair_p1", p1, 32);
    chk("pair_p2", p2, 33);
    chk("pair_count", free_count, 94);

    // p0 release is dropped
    cycle(0, 0, 1, 0, 0, 0, g1, g2, p1, p2);
    chk("p0_count", free_count, 94);

    // drain down to one entry
    for (int i = 0; i < 46; i++) cycle(1, 1, 0, 0, 0, 0, g1, g2, p1, p2);
    cycle(1, 0, 0, 0, 0, 0, g1, g2, p1, p2);
    chk("drain_count", free_count, 1);
    cycle(1, 1, 0, 0, 0, 0, g1, g2, p1, p2);
    chk("stall_gnt", {g1, g2}, 2'b00);
    chk("stall_count", free_count, 1);
    cycle(0, 1, 0, 0, 0, 0, g1, g2, p1, p2);
    chk("last_gnt_2", g2, 1);
    chk("last_preg", p2, 127);
    chk("last_empty", empty, 1);

    // freed preg is not allocatable in its own cycle
    out_remove(7'd40);
    cycle(1, 1, 1, 7'd40, 0, 0, g1, g2, p1, p2);
    chk("nobypass_gnt", {g1, g2}, 2'b00);
    cycle(1, 0, 0, 0, 0, 0, g1, g2, p1, p2);
    chk("bypass_next_gnt", g1, 1);
    chk("bypass_next_preg", p1, 40);

    // randomized traffic, long enough to wrap the pointers several times
    for (int i = 0; i < 500; i++) begin
      fae = 0; fbe = 0; fa = '0; fb = '0;
      if (out_q.size() > 0 && $urandom_range(0, 9) < 6) begin
        int k = $urandom_range(0, out_q.size() - 1);
        fa = out_q[k]; out_q.delete(k); fae = 1;
      end
      if (out_q.size() > 0 && $urandom_range(0, 9) < 4) begin
        int k = $urandom_range(0, out_q.size() - 1);
        fb = out_q[k]; out_q.delete(k); fbe = 1;
      end else if ($urandom_range(0, 15) == 0) begin
        fbe = 1; fb = '0;
      end
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), fae, fa, fbe, fb,
            g1, g2, p1, p2);
    end
    while (out_q.size() > 0) begin
      fa = out_q.pop_front();
      fbe = out_q.size() > 0;
      fb = fbe ? out_q.pop_front() : 7'd0;
      cycle(0, 0, 1, fa, fbe, fb, g1, g2, p1, p2);
    end
    chk("refill_count", free_count, 96);

    // reset in the middle of traffic discards that cycle's requests and frees
    reset = 1;
    alloc_req_1 = 1; alloc_req_2 = 1;
    free_en_1 = 1; free_preg_1 = 7'd5;
    #1;
    chk("midrst_gnt", {alloc_gnt_1, alloc_gnt_2}, 2'b00);
    @(posedge clk); #1;
    drive_idle();
    chk("midrst_count", free_count, 96);
    chk("midrst_preg", alloc_preg_1, 32);
    @(negedge clk);
    reset = 0;
    model_reset();
    cycle(1, 1, 0, 0, 0, 0, g1, g2, p1, p2);
    chk("midrst_pair", {p1, p2}, {7'd32, 7'd33});

`ifdef FREELIST_DBL_FREE_CHK_EN
    for (int i = 0; i < 9; i++) cycle(1, 1, 0, 0, 0, 0, g1, g2, p1, p2);
    chk("dbl_pre_count", free_count, 76);
    free_en_1 = 1; free_preg_1 = 7'd50;
    free_en_2 = 1; free_preg_2 = 7'd50;
    @(posedge clk); #1;
    drive_idle();
    out_remove(7'd50);
    fl.push_back(7'd50);
    chk("dbl_same_cycle_count", free_count, 77);
    chk("dbl_err", err_dbl_free, 1);
    @(negedge clk);
    free_en_1 = 1; free_preg_1 = 7'd50;
    @(posedge clk); #1;
    drive_idle();
    chk("dbl_inlist_count", free_count, 77);
    chk("dbl_err_sticky", err_dbl_free, 1);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    #1;
    chk("dbl_err_cleared", err_dbl_free, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
